// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divider controller.
package clk_div_ctrl_pkg;

  // Default width of a divide ratio
  localparam int unsigned DIV_W_DEFAULT = 16;

  // Smallest ratio that still produces a toggling output
  localparam int unsigned MIN_DIV = 2;

  // Controller states: IDLE accepts requests, WAIT holds a ratio until the next boundary
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// rotating pointer; the pointer moves past the winner when advanced.
module clk_div_ctrl_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_pos;

  // Scan from the lowest priority upward so the highest-priority hit wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, r_ptr} + (IDX_W + 1)'(k);
      if (w_pos >= (IDX_W + 1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_gnt                     = '0;
        o_gnt[w_pos[IDX_W-1:0]]   = 1'b1;
        o_idx                     = w_pos[IDX_W-1:0];
        o_valid                   = 1'b1;
      end
    end
  end

  // Pointer moves to the requester after the winner on each accepted grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_adv && o_valid) begin
      r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Reconfigurable clock-divider controller. Arbitrates ratio change requests
// round-robin and swaps the active ratio only at an output period boundary.
// Optional build macro CLK_DIV_CTRL_CHGCNT_EN adds o_chg_cnt, a saturating
// count of applied ratio changes.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*DIV_W-1:0] i_div,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [DIV_W-1:0]         o_div_active,
  output logic                     o_frequency,
  output logic                     o_period_start
`ifdef CLK_DIV_CTRL_CHGCNT_EN
  ,
  output logic [7:0]               o_chg_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_cnt, r_div_active, r_pending;
  logic [DIV_W-1:0]   w_cnt_nxt, w_d_nxt, w_pend_nxt, w_sel_div;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt, w_req_eff, w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               r_err, w_err_nxt, r_busy, w_busy_nxt;
  logic               r_freq, r_ps;
  logic               w_bound, w_apply, w_adv, w_gnt_vld;

  // A request is still high during its own ack cycle; hide it so a rejected
  // request is not granted twice.
  assign w_req_eff = i_req & ~r_ack;

  clk_div_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_req   (w_req_eff),
    .i_adv   (w_adv),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_vld)
  );

  assign w_sel_div = i_div[int'(w_gnt_idx) * DIV_W +: DIV_W];

  assign w_bound   = (r_cnt == r_div_active - 1'b1);
  assign w_apply   = (r_state == WAIT) && w_bound;
  assign w_cnt_nxt = w_bound ? '0 : r_cnt + 1'b1;
  // The first cycle of a new period is decoded with the ratio being installed
  assign w_d_nxt   = w_apply ? r_pending : r_div_active;

  // Next-state and registered-output decode for the request FSM
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = r_busy;
    w_pend_nxt  = r_pending;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_adv     = 1'b1;
          w_ack_nxt = w_gnt;
          if (w_sel_div < DIV_W'(MIN_DIV)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pend_nxt  = w_sel_div;
            w_busy_nxt  = 1'b1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (w_apply) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state and handshake registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  // Divide counter and registered clock/period-start decode
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt        <= DIV_W'(DEFAULT_DIV - 1);
      r_div_active <= DIV_W'(DEFAULT_DIV);
      r_freq       <= 1'b0;
      r_ps         <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_apply) begin
        r_div_active <= r_pending;
      end
      r_freq <= (w_cnt_nxt < (w_d_nxt >> 1));
      r_ps   <= (w_cnt_nxt == '0);
    end
  end

`ifdef CLK_DIV_CTRL_CHGCNT_EN
  logic [7:0] r_chg_cnt;

  // Saturating count of ratios actually installed at a boundary
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_chg_cnt <= '0;
    end else if (w_apply && (r_chg_cnt != 8'hFF)) begin
      r_chg_cnt <= r_chg_cnt + 1'b1;
    end
  end

  assign o_chg_cnt = r_chg_cnt;
`else
  // Change counter not built
`endif

  assign o_ack          = r_ack;
  assign o_err          = r_err;
  assign o_busy         = r_busy;
  assign o_div_active   = r_div_active;
  assign o_frequency    = r_freq;
  assign o_period_start = r_ps;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: scenario tasks with an expected-waveform queue
// and an expected-grant queue.
module tb_clk_div_ctrl;

  localparam int NUM_REQ = 2;
  localparam int DIV_W   = 16;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DIV_W-1:0] div;
  logic [NUM_REQ-1:0]       o_ack;
  logic                     o_err;
  logic                     o_busy;
  logic [DIV_W-1:0]         o_div_active;
  logic                     o_frequency;
  logic                     o_period_start;
`ifdef CLK_DIV_CTRL_CHGCNT_EN
  logic [7:0]               o_chg_cnt;
`endif

  int errors;
  int checks;

  logic [1:0] exp_q[$];   // {frequency, period_start} per cycle
  logic [2:0] gnt_q[$];   // {ack[1:0], err} per expected grant
  logic [1:0] ew;
  logic [2:0] eg;

  clk_div_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_req          (req),
    .i_div          (div),
    .o_ack          (o_ack),
    .o_err          (o_err),
    .o_busy         (o_busy),
    .o_div_active   (o_div_active),
    .o_frequency    (o_frequency),
    .o_period_start (o_period_start)
`ifdef CLK_DIV_CTRL_CHGCNT_EN
    ,
    .o_chg_cnt      (o_chg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle output of one period of ratio d
  function automatic void push_period(int d);
    for (int i = 0; i < d; i++) begin
      exp_q.push_back({(i < d / 2), (i == 0)});
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    div   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({o_frequency, o_period_start, o_ack, o_err, o_busy, o_div_active} !== {6'b000000, 16'd4}) begin
      errors++;
      $display("FAIL reset_values got=%b/%b/%b/%b/%b/%0d exp=0/0/00/0/0/4",
               o_frequency, o_period_start, o_ack, o_err, o_busy, o_div_active);
    end
    rst_n = 1'b1;
    push_period(4); push_period(4); push_period(4);
    for (int c = 1; c <= 12; c++) begin
      tick();
      ew = exp_q.pop_front();
      checks++;
      if ({o_frequency, o_period_start} !== ew) begin
        errors++;
        $display("FAIL wave_reset c=%0d got=%b exp=%b", c, {o_frequency, o_period_start}, ew);
      end
      checks++;
      if (o_busy !== 1'b0 || o_div_active !== 16'd4 || o_ack !== 2'b00 || o_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_reset c=%0d busy=%b div=%0d ack=%b err=%b exp 0/4/00/0",
                 c, o_busy, o_div_active, o_ack, o_err);
      end
    end
  endtask

  task automatic test_ratio_change();
    do_reset();
    push_period(4); push_period(6); push_period(6);
    for (int c = 1; c <= 16; c++) begin
      tick();
      ew = exp_q.pop_front();
      checks++;
      if ({o_frequency, o_period_start} !== ew) begin
        errors++;
        $display("FAIL wave_chg c=%0d got=%b exp=%b", c, {o_frequency, o_period_start}, ew);
      end
      if (o_ack !== '0 || o_err !== 1'b0) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_chg c=%0d got ack=%b err=%b exp none", c, o_ack, o_err);
        end else begin
          eg = gnt_q.pop_front();
          if ({o_ack, o_err} !== eg) begin
            errors++;
            $display("FAIL grant_chg c=%0d got=%b exp=%b", c, {o_ack, o_err}, eg);
          end
        end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_chg c=%0d got=%b exp=1", c, o_busy);
        end
      end
      if (c == 4) begin
        checks++;
        if (o_div_active !== 16'd4) begin
          errors++;
          $display("FAIL div_early c=%0d got=%0d exp=4", c, o_div_active);
        end
      end
      if (c == 5) begin
        checks++;
        if (o_busy !== 1'b0 || o_div_active !== 16'd6) begin
          errors++;
          $display("FAIL apply_chg c=%0d busy=%b div=%0d exp 0/6", c, o_busy, o_div_active);
        end
      end
      if (c == 2) begin
        req[0] = 1'b1; div[15:0] = 16'd6;
        gnt_q.push_back({2'b01, 1'b0});
      end
      if (c == 4) req[0] = 1'b0;
    end
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL grant_missing_chg got=%0d outstanding exp=0", gnt_q.size());
    end
  endtask

  task automatic test_two_requests();
    do_reset();
    push_period(4); push_period(8);
    for (int p = 0; p < 5; p++) push_period(10);
    for (int c = 1; c <= 62; c++) begin
      tick();
      ew = exp_q.pop_front();
      checks++;
      if ({o_frequency, o_period_start} !== ew) begin
        errors++;
        $display("FAIL wave_two c=%0d got=%b exp=%b", c, {o_frequency, o_period_start}, ew);
      end
      if (o_ack !== '0 || o_err !== 1'b0) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_two c=%0d got ack=%b err=%b exp none", c, o_ack, o_err);
        end else begin
          eg = gnt_q.pop_front();
          if ({o_ack, o_err} !== eg) begin
            errors++;
            $display("FAIL grant_two c=%0d got=%b exp=%b", c, {o_ack, o_err}, eg);
          end
        end
      end
      if (c == 5) begin
        checks++;
        if (o_div_active !== 16'd8 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL apply8 c=%0d div=%0d busy=%b exp 8/0", c, o_div_active, o_busy);
        end
      end
      if (c == 13 || c == 62) begin
        checks++;
        if (o_div_active !== 16'd10 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL apply10 c=%0d div=%0d busy=%b exp 10/0", c, o_div_active, o_busy);
        end
      end
      if (c == 25) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_same c=%0d got=%b exp=1", c, o_busy);
        end
      end
      if (c == 1) begin
        req = 2'b11; div = {16'd10, 16'd8};
        gnt_q.push_back({2'b01, 1'b0});
        gnt_q.push_back({2'b10, 1'b0});
      end
      if (c == 3) req[0] = 1'b0;
      if (c == 7) req[1] = 1'b0;
      if (c == 24) begin
        req = 2'b11; div = {16'd10, 16'd10};
        gnt_q.push_back({2'b01, 1'b0});
        gnt_q.push_back({2'b10, 1'b0});
      end
      if (c == 26) req[0] = 1'b0;
      if (c == 35) req[1] = 1'b0;
    end
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL grant_missing_two got=%0d outstanding exp=0", gnt_q.size());
    end
  endtask

  task automatic test_reject();
    do_reset();
    push_period(4); push_period(4); push_period(4);
    for (int c = 1; c <= 12; c++) begin
      tick();
      ew = exp_q.pop_front();
      checks++;
      if ({o_frequency, o_period_start} !== ew) begin
        errors++;
        $display("FAIL wave_rej c=%0d got=%b exp=%b", c, {o_frequency, o_period_start}, ew);
      end
      if (o_ack !== '0 || o_err !== 1'b0) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_rej c=%0d got ack=%b err=%b exp none", c, o_ack, o_err);
        end else begin
          eg = gnt_q.pop_front();
          if ({o_ack, o_err} !== eg) begin
            errors++;
            $display("FAIL grant_rej c=%0d got=%b exp=%b", c, {o_ack, o_err}, eg);
          end
        end
      end
      checks++;
      if (o_busy !== 1'b0 || o_div_active !== 16'd4) begin
        errors++;
        $display("FAIL state_rej c=%0d busy=%b div=%0d exp 0/4", c, o_busy, o_div_active);
      end
      if (c == 2) begin
        req[1] = 1'b1; div[31:16] = 16'd1;
        gnt_q.push_back({2'b10, 1'b1});
      end
      if (c == 4) req[1] = 1'b0;
    end
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL grant_missing_rej got=%0d outstanding exp=0", gnt_q.size());
    end
  endtask

  task automatic test_odd_and_reset();
    do_reset();
    push_period(4); push_period(5); push_period(5);
    for (int c = 1; c <= 13; c++) begin
      tick();
      ew = exp_q.pop_front();
      checks++;
      if ({o_frequency, o_period_start} !== ew) begin
        errors++;
        $display("FAIL wave_odd c=%0d got=%b exp=%b", c, {o_frequency, o_period_start}, ew);
      end
      if (o_ack !== '0 || o_err !== 1'b0) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_odd c=%0d got ack=%b err=%b exp none", c, o_ack, o_err);
        end else begin
          eg = gnt_q.pop_front();
          if ({o_ack, o_err} !== eg) begin
            errors++;
            $display("FAIL grant_odd c=%0d got=%b exp=%b", c, {o_ack, o_err}, eg);
          end
        end
      end
      if (c == 13) begin
        checks++;
        if (o_busy !== 1'b1 || o_div_active !== 16'd5) begin
          errors++;
          $display("FAIL wait_odd c=%0d busy=%b div=%0d exp 1/5", c, o_busy, o_div_active);
        end
      end
      if (c == 1) begin
        req[0] = 1'b1; div[15:0] = 16'd5;
        gnt_q.push_back({2'b01, 1'b0});
      end
      if (c == 3) req[0] = 1'b0;
      if (c == 10) begin
        req[1] = 1'b1; div[31:16] = 16'd12;
        gnt_q.push_back({2'b10, 1'b0});
      end
      if (c == 12) req[1] = 1'b0;
    end
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL grant_missing_odd got=%0d outstanding exp=0", gnt_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_frequency, o_period_start, o_ack, o_err, o_busy, o_div_active} !== {6'b000000, 16'd4}) begin
      errors++;
      $display("FAIL reset_midwait got=%b/%b/%b/%b/%b/%0d exp=0/0/00/0/0/4",
               o_frequency, o_period_start, o_ack, o_err, o_busy, o_div_active);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_period(4); push_period(4);
    for (int c = 1; c <= 8; c++) begin
      tick();
      ew = exp_q.pop_front();
      checks++;
      if ({o_frequency, o_period_start} !== ew || o_busy !== 1'b0 || o_div_active !== 16'd4) begin
        errors++;
        $display("FAIL after_reset c=%0d wave=%b busy=%b div=%0d exp wave=%b busy=0 div=4",
                 c, {o_frequency, o_period_start}, o_busy, o_div_active, ew);
      end
    end
  endtask

`ifdef CLK_DIV_CTRL_CHGCNT_EN
  task automatic handshake(input int k, input int d, output bit ok);
    req[k] = 1'b1;
    div[k*DIV_W +: DIV_W] = DIV_W'(d);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (o_ack[k]) ok = 1'b1;
    end
    tick();
    req[k] = 1'b0;
    for (int i = 0; i < 40 && o_busy; i++) tick();
    if (o_busy) ok = 1'b0;
  endtask

  task automatic test_chg_cnt();
    bit ok;
    int bad;
    do_reset();
    bad = 0;
    handshake(0, 3, ok); if (!ok) bad++;
    handshake(1, 0, ok); if (!ok) bad++;
    handshake(0, 2, ok); if (!ok) bad++;
    handshake(1, 5, ok); if (!ok) bad++;
    checks++;
    if (o_chg_cnt !== 8'd3 || bad != 0) begin
      errors++;
      $display("FAIL chg_cnt3 got=%0d timeouts=%0d exp=3 timeouts=0", o_chg_cnt, bad);
    end
    for (int n = 0; n < 297; n++) begin
      handshake(n % 2, 2, ok);
      if (!ok) bad++;
    end
    checks++;
    if (o_chg_cnt !== 8'd255 || bad != 0) begin
      errors++;
      $display("FAIL chg_cnt_sat got=%0d timeouts=%0d exp=255 timeouts=0", o_chg_cnt, bad);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    req    = '0;
    div    = '0;
    #2;
    rst_n  = 1'b0;
    test_reset();
    test_ratio_change();
    test_two_requests();
    test_reject();
    test_odd_and_reset();
`ifdef CLK_DIV_CTRL_CHGCNT_EN
    test_chg_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Shared, reconfigurable clock-divider controller. Owns the divide counter that produces o_frequency.
- Accepts divide-ratio change requests from NUM_REQ requesters and arbitrates them round-robin.
- Applies each accepted ratio glitch-free, only at a period boundary.
- Sits between the configuration masters and the divided-clock consumers.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DIV_W, 16, width of divide ratio.
- DEFAULT_DIV, 4, ratio active out of reset (≥2).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-low
- i_req  in  NUM_REQ  per-requester request; held high until o_ack
- i_div  in  NUM_REQ*DIV_W  requested ratio, slice k belongs to requester k; stable while i_req[k]
- o_ack  out  NUM_REQ  one-cycle grant pulse
- o_err  out  1  one-cycle pulse with o_ack when the granted ratio was rejected
- o_busy  out  1  high while an accepted ratio is pending
- o_div_active  out  DIV_W  ratio currently in effect
- o_frequency  out  1  divided clock output (registered)
- o_period_start  out  1  high during the first cycle of each output period

Behaviour:
- Reset values (async assert, sync release):
  - cnt = DEFAULT_DIV-1, o_div_active = DEFAULT_DIV, pending = 0, state IDLE.
  - o_frequency = 0, o_period_start = 0, o_ack = 0, o_err = 0, o_busy = 0.
  - Round-robin pointer = 0 (requester 0 has highest priority).
- Counter, with D = o_div_active:
  - Each edge: cnt <= (cnt == D-1) ? 0 : cnt+1.
  - o_frequency <= (cnt_next < D>>1).
  - o_period_start <= (cnt_next == 0).
  - Even D gives 50% duty. Odd D is high for (D-1)/2 cycles and low for (D+1)/2 cycles.
  - The first edge after reset release starts a period: o_frequency = 1, o_period_start = 1.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any i_req is high, grant the first requester at or after the pointer, cyclically.
  - Register o_ack[g] = 1 for one cycle. The pointer moves to g+1 mod NUM_REQ.
  - If i_div[g] < 2: o_err = 1 that cycle, the ratio is discarded, and the FSM stays in IDLE.
  - Otherwise: pending <= i_div[g], o_busy <= 1, go to WAIT.
  - Latency from i_req high to o_ack high is 1 cycle.
- WAIT:
  - No grants are issued; requests stay pending.
  - On the edge where cnt == D-1: cnt <= 0, o_div_active <= pending, and o_frequency/o_period_start are decoded using pending.
  - On that same edge: o_busy <= 0, go to IDLE.
  - The new ratio is therefore effective from the very next period start. There are no truncated periods and no glitches.
- Requesters drop i_req in the cycle after o_ack. A request still high one cycle after its ack counts as a new request.
- Grant in IDLE on the same edge as a boundary: the old period ends normally, and the new ratio applies at the following boundary.
- Reset mid-WAIT: the pending ratio is lost; the block restarts at DEFAULT_DIV.
- A ratio equal to o_div_active is accepted and applied as normal, with no visible change.

Optional Feature:
- Macro: CLK_DIV_CTRL_CHGCNT_EN.
- Defined:
  - Adds output o_chg_cnt[7:0], reset 0.
  - Increments on every boundary where pending is applied; saturates at 255.
  - Rejected requests do not count.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package clk_div_ctrl_pkg holds:
  - the state enum typedef (IDLE, WAIT);
  - the MIN_DIV = 2 constant;
  - the DIV_W default localparam.
- One natural sub-module, rr_arbiter: NUM_REQ-wide round-robin arbiter.
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant and grant index.

Test Plan:
- Reset release, no requests: o_frequency pattern 1,1,0,0 repeating (D=4); o_period_start every 4th cycle, first at cycle 1 after release.
- req0 with div=6 raised mid-period at cnt=1:
  - o_ack[0] the next cycle, o_busy high.
  - The current 4-cycle period completes, then periods are 6 cycles (3 high, 3 low), o_div_active=6.
  - o_busy falls at that boundary.
- req0=1 and req1=1 simultaneously with 8 and 10, pointer=0:
  - ack0 first, 8 applied.
  - Then ack1 in the IDLE cycle after that boundary, 10 applied at the next boundary.
  - Pointer ends at 0.
- req1 with div=1: o_ack[1] and o_err the same cycle; o_busy stays 0; o_div_active unchanged; no period disturbed.
- Odd ratio 5: high 2 cycles, low 3 cycles. Then assert i_reset low mid-WAIT with pending 12: all outputs return to reset values immediately; after release D=4.
- With CLK_DIV_CTRL_CHGCNT_EN: 3 accepted changes plus 1 rejected give o_chg_cnt=3. 300 accepted changes give 255.
